// File: rtl/fpdiv_ctrl.sv
// -----------------------------------------------------------------------------
// fpdiv_ctrl -- sequencer for a Goldschmidt floating-point divider datapath.
//
// One division runs as follows:
//   INIT_D : regB <= ia*d, regA <= ~(ia*d)      (first divisor product / factor)
//   INIT_Q : regC <= ia*x                       (first quotient estimate)
//   ITERS times:
//     ITER_Q : regC <= K*Q                      (quotient refinement)
//     ITER_D : regB <= K*D, regA <= ~(K*D)      (skipped on the last pass)
//   DONE   : one-cycle done pulse, regC holds the quotient
// ITER_Q comes before ITER_D so the quotient update reads regA before the
// divisor update overwrites it.
//
// Parameters
//   ITERS     number of refinement iterations, legal range 1..7
// Ports
//   clock     rising-edge clock
//   reset     synchronous, active-high reset
//   start     begin one division (ignored while busy)
//   sel_muxa  A-mux select: 0 regA, 1 d, 2 ia
//   sel_muxb  B-mux select: 0 d, 1 x, 2 regB, 3 regC
//   enA/enB/enC  load enables for regA/regB/regC
//   busy      high from INIT_D through the last ITER_Q
//   done      one-cycle pulse in the DONE state
//   iter_cnt  current refinement iteration index
// All outputs are Moore outputs decoded from the state and counter registers.
// -----------------------------------------------------------------------------
module fpdiv_ctrl #(
  parameter int ITERS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic [1:0] sel_muxa,
  output logic [1:0] sel_muxb,
  output logic       enA,
  output logic       enB,
  output logic       enC,
  output logic       busy,
  output logic       done,
  output logic [2:0] iter_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_D,
    S_INIT_Q,
    S_ITER_Q,
    S_ITER_D,
    S_DONE
  } state_t;

  // Mux encodings, named so the decode below reads like the schedule.
  localparam logic [1:0] A_REGA = 2'd0;
  localparam logic [1:0] A_IA   = 2'd2;
  localparam logic [1:0] B_D    = 2'd0;
  localparam logic [1:0] B_X    = 2'd1;
  localparam logic [1:0] B_REGB = 2'd2;
  localparam logic [1:0] B_REGC = 2'd3;

  localparam logic [2:0] LAST_ITER = 3'(ITERS - 1);

  state_t     state_q, state_d;
  logic [2:0] iter_cnt_q, iter_cnt_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      iter_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      iter_cnt_q <= iter_cnt_d;
    end
  end

  // Next-state and output decode.
  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    iter_cnt_d = iter_cnt_q;
    sel_muxa   = A_REGA;
    sel_muxb   = B_D;
    enA        = 1'b0;
    enB        = 1'b0;
    enC        = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_INIT_D;
          iter_cnt_d = '0;
        end
      end

      S_INIT_D: begin
        sel_muxa = A_IA;
        sel_muxb = B_D;
        enA      = 1'b1;
        enB      = 1'b1;
        busy     = 1'b1;
        state_d  = S_INIT_Q;
      end

      S_INIT_Q: begin
        sel_muxa = A_IA;
        sel_muxb = B_X;
        enC      = 1'b1;
        busy     = 1'b1;
        state_d  = S_ITER_Q;
      end

      S_ITER_Q: begin
        sel_muxa = A_REGA;
        sel_muxb = B_REGC;
        enC      = 1'b1;
        busy     = 1'b1;
        // The last pass needs no divisor update, so it goes straight to DONE.
        state_d  = (iter_cnt_q == LAST_ITER) ? S_DONE : S_ITER_D;
      end

      S_ITER_D: begin
        sel_muxa   = A_REGA;
        sel_muxb   = B_REGB;
        enA        = 1'b1;
        enB        = 1'b1;
        busy       = 1'b1;
        iter_cnt_d = iter_cnt_q + 3'd1;
        state_d    = S_ITER_Q;
      end

      S_DONE: begin
        done = 1'b1;
        // A start here chains the next division with no idle gap.
        if (start) begin
          state_d    = S_INIT_D;
          iter_cnt_d = '0;
        end else begin
          state_d    = S_IDLE;
        end
      end

      default: begin
        state_d    = S_IDLE;
        iter_cnt_d = '0;
      end
    endcase
  end

  assign iter_cnt = iter_cnt_q;

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fpdiv_ctrl -- self-checking bench for fpdiv_ctrl.
//
// Three controllers (ITERS = 1, 2, 3) share one clock, start and reset.
// Each is compared every cycle against a schedule model: a division is a
// position 1..2*ITERS+2 along the fixed phase list INIT_D, INIT_Q,
// (ITER_Q, ITER_D)*, ITER_Q, DONE, and the expected outputs come from a
// per-phase table.  Directed sequences cover the multi-cycle corner cases,
// and a small fixed-point datapath attached to the ITERS=3 instance checks
// that the produced control sequence computes a quotient.
// -----------------------------------------------------------------------------
module tb_fpdiv_ctrl;

  localparam int NDUT = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;

  logic [1:0] sel_a [NDUT];
  logic [1:0] sel_b [NDUT];
  logic       en_a  [NDUT];
  logic       en_b  [NDUT];
  logic       en_c  [NDUT];
  logic       busy  [NDUT];
  logic       done  [NDUT];
  logic [2:0] cnt   [NDUT];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  fpdiv_ctrl #(.ITERS(1)) dut1 (
    .clock(clock), .reset(reset), .start(start),
    .sel_muxa(sel_a[0]), .sel_muxb(sel_b[0]),
    .enA(en_a[0]), .enB(en_b[0]), .enC(en_c[0]),
    .busy(busy[0]), .done(done[0]), .iter_cnt(cnt[0])
  );

  fpdiv_ctrl #(.ITERS(2)) dut2 (
    .clock(clock), .reset(reset), .start(start),
    .sel_muxa(sel_a[1]), .sel_muxb(sel_b[1]),
    .enA(en_a[1]), .enB(en_b[1]), .enC(en_c[1]),
    .busy(busy[1]), .done(done[1]), .iter_cnt(cnt[1])
  );

  fpdiv_ctrl #(.ITERS(3)) dut3 (
    .clock(clock), .reset(reset), .start(start),
    .sel_muxa(sel_a[2]), .sel_muxb(sel_b[2]),
    .enA(en_a[2]), .enB(en_b[2]), .enC(en_c[2]),
    .busy(busy[2]), .done(done[2]), .iter_cnt(cnt[2])
  );

  // ---------------------------------------------------------------------------
  // Fixed-point datapath on the ITERS=3 instance (1.0 = 2**26).
  // ---------------------------------------------------------------------------
  localparam logic [63:0] FX_ONE  = 64'h400_0000;
  localparam logic [63:0] D_VAL   = 64'h400_0000;
  localparam logic [63:0] X_VAL   = 64'h600_0000;
  localparam logic [63:0] IA_VAL  = 64'h400_0000;
  localparam logic [63:0] K_MASK  = 64'h7FF_FFFF;

  logic [63:0] reg_a = '0, reg_b = '0, reg_c = '0;
  logic [63:0] op_a, op_b, prod;

  always @(posedge clock) begin
    case (sel_a[2])
      2'd0:    op_a = reg_a;
      2'd1:    op_a = D_VAL;
      default: op_a = IA_VAL;
    endcase
    case (sel_b[2])
      2'd0:    op_b = D_VAL;
      2'd1:    op_b = X_VAL;
      2'd2:    op_b = reg_b;
      default: op_b = reg_c;
    endcase
    prod = (op_a * op_b) / FX_ONE;
    if (en_b[2]) reg_b <= prod;
    if (en_a[2]) reg_a <= (~prod) & K_MASK;
    if (en_c[2]) reg_c <= prod;
  end

  // ---------------------------------------------------------------------------
  // Reference model: position along the division schedule.
  // ---------------------------------------------------------------------------
  localparam int K_IDLE = 0, K_INIT_D = 1, K_INIT_Q = 2,
                 K_ITER_Q = 3, K_ITER_D = 4, K_DONE = 5;

  int pos  [NDUT] = '{0, 0, 0};
  int mcnt [NDUT] = '{0, 0, 0};

  function automatic int iters_of(int k);
    return k + 1;
  endfunction

  function automatic int kind_of(int p, int iters);
    if (p == 0)             return K_IDLE;
    if (p == 1)             return K_INIT_D;
    if (p == 2)             return K_INIT_Q;
    if (p == 2 * iters + 2) return K_DONE;
    return ((p - 3) % 2 == 0) ? K_ITER_Q : K_ITER_D;
  endfunction

  function automatic int iter_idx(int p, int iters);
    int kd;
    kd = kind_of(p, iters);
    if (kd == K_ITER_Q || kd == K_ITER_D) return (p - 3) / 2;
    if (kd == K_DONE)                     return iters - 1;
    return 0;
  endfunction

  // {sel_muxa, sel_muxb, enA, enB, enC, busy, done} for each phase.
  function automatic logic [8:0] out_of_kind(int kd);
    case (kd)
      K_INIT_D: return {2'd2, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      K_INIT_Q: return {2'd2, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      K_ITER_Q: return {2'd0, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      K_ITER_D: return {2'd0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      K_DONE:   return {2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      default:  return 9'd0;
    endcase
  endfunction

  function automatic logic [11:0] act_bundle(int k);
    return {sel_a[k], sel_b[k], en_a[k], en_b[k], en_c[k], busy[k], done[k], cnt[k]};
  endfunction

  task automatic model_update(input logic st, input logic rst);
    for (int k = 0; k < NDUT; k++) begin
      int last;
      last = 2 * iters_of(k) + 2;
      if (rst) begin
        pos[k]  = 0;
        mcnt[k] = 0;
      end else if (pos[k] != 0 && pos[k] != last) begin
        pos[k] = pos[k] + 1;
      end else begin
        pos[k] = st ? 1 : 0;
      end
      // In IDLE the counter keeps whatever it last held.
      if (pos[k] != 0) mcnt[k] = iter_idx(pos[k], iters_of(k));
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  int cyc = 0;

  // Drive inputs, take one edge, then compare all instances with the model.
  task automatic step(input logic st, input logic rst);
    start = st;
    reset = rst;
    @(posedge clock);
    #1;
    cyc++;
    model_update(st, rst);
    for (int k = 0; k < NDUT; k++) begin
      logic [11:0] exp;
      exp = {out_of_kind(kind_of(pos[k], iters_of(k))), 3'(mcnt[k])};
      check($sformatf("model_i%0d_c%0d", iters_of(k), cyc), 32'(act_bundle(k)), 32'(exp));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table for the ITERS=3 instance.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       st;
    logic       rst;
    logic [1:0] sa;
    logic [1:0] sb;
    logic       ea, eb, ec, bz, dn;
    logic [2:0] cn;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int ndone;
    logic [63:0] diff;

    // Reset with start asserted (reset wins), then one full ITERS=3 division.
    vecs[0] = '{1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0}; // IDLE
    vecs[1] = '{1'b1, 1'b0, 2'd2, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0}; // INIT_D
    vecs[2] = '{1'b0, 1'b0, 2'd2, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0}; // INIT_Q
    vecs[3] = '{1'b0, 1'b0, 2'd0, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0}; // ITER_Q 0
    vecs[4] = '{1'b0, 1'b0, 2'd0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0}; // ITER_D 0
    vecs[5] = '{1'b0, 1'b0, 2'd0, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1}; // ITER_Q 1
    vecs[6] = '{1'b0, 1'b0, 2'd0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1}; // ITER_D 1
    vecs[7] = '{1'b0, 1'b0, 2'd0, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2}; // ITER_Q 2
    vecs[8] = '{1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2}; // DONE
    vecs[9] = '{1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2}; // IDLE

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].st, vecs[i].rst);
      check($sformatf("vec%0d", i), 32'(act_bundle(2)),
            32'({vecs[i].sa, vecs[i].sb, vecs[i].ea, vecs[i].eb, vecs[i].ec,
                 vecs[i].bz, vecs[i].dn, vecs[i].cn}));
      if (i == 8) begin
        // Quotient 1.5/1.0 must land within 2 LSB of 0x6000000.
        diff = (reg_c > X_VAL) ? reg_c - X_VAL : X_VAL - reg_c;
        n_checks++;
        if (diff > 64'd2) begin
          n_errors++;
          $display("FAIL quotient: got %h expected %h +/-2", reg_c, X_VAL);
        end
      end
    end

    // start held for 20 cycles, ITERS=2: done every 6th cycle, no idle gap.
    step(1'b0, 1'b1);
    for (int c = 1; c <= 20; c++) begin
      step(1'b1, 1'b0);
      check($sformatf("hold_done_c%0d", c), 32'(done[1]), 32'(c % 6 == 0));
      check($sformatf("hold_busy_c%0d", c), 32'(busy[1]), 32'(c % 6 != 0));
    end
    for (int c = 0; c < 12; c++) step(1'b0, 1'b0);

    // start pulsed in INIT_Q and in ITER_D is ignored, ITERS=3.
    ndone = 0;
    for (int c = 1; c <= 12; c++) begin
      step((c == 1) || (c == 3) || (c == 5), 1'b0);
      if (done[2]) begin
        ndone++;
        check("ignore_done_cycle", 32'(c), 32'd8);
      end
    end
    check("ignore_done_count", 32'(ndone), 32'd1);

    // Reset during the second ITER_Q aborts; restart right after completes.
    step(1'b1, 1'b0);                      // INIT_D
    for (int c = 2; c <= 5; c++) step(1'b0, 1'b0);
    check("abort_pre_state", 32'(act_bundle(2)),
          32'({2'd0, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1}));
    step(1'b0, 1'b1);
    check("abort_idle", 32'(act_bundle(2)), 32'd0);
    ndone = 0;
    for (int c = 1; c <= 9; c++) begin
      step(c == 1, 1'b0);
      if (done[2]) begin
        ndone++;
        check("restart_done_cycle", 32'(c), 32'd8);
      end
    end
    check("restart_done_count", 32'(ndone), 32'd1);

    // ITERS=1: INIT_D, INIT_Q, ITER_Q, DONE; enB only in INIT_D; cnt stays 0.
    step(1'b0, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      step(c == 1, 1'b0);
      check($sformatf("i1_enb_c%0d", c),  32'(en_b[0]), 32'(c == 1));
      check($sformatf("i1_done_c%0d", c), 32'(done[0]), 32'(c == 4));
      check($sformatf("i1_cnt_c%0d", c),  32'(cnt[0]),  32'd0);
    end

    // Random start/reset traffic against the schedule model.
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fpdiv_ctrl.md
FPDIV_CTRL -- requirements
Module: fpdiv_ctrl

Interface
REQ-001 Parameter ITERS, default 3, number of Goldschmidt quotient-refinement iterations; legal range 1..7.
REQ-002 clock  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin one division; sampled on the rising clock edge.
REQ-005 sel_muxa  output  2  A-mux select: 0 = regA (complement factor), 1 = divisor d, 2 = initial approximation ia.
REQ-006 sel_muxb  output  2  B-mux select: 0 = d, 1 = dividend x, 2 = regB (divisor product), 3 = regC (quotient product).
REQ-007 enA, enB, enC  output  1 each  load enables for regA, regB and regC of the divider datapath.
REQ-008 busy  output  1  high while a division sequence is in progress.
REQ-009 done  output  1  one-cycle pulse: regC holds the final quotient.
REQ-010 iter_cnt  output  3  index of the current refinement iteration, 0..ITERS-1.

Function
REQ-011 Moore FSM with states IDLE, INIT_D, INIT_Q, ITER_Q, ITER_D, DONE; every output decodes from the registered state and counter only.
REQ-012 IDLE: sel_muxa=0, sel_muxb=0, enA=enB=enC=0, busy=0, done=0; start=1 -> INIT_D and iter_cnt cleared to 0; otherwise stay.
REQ-013 INIT_D: sel_muxa=2, sel_muxb=0, enA=1, enB=1, enC=0 (regB<=ia*d, regA<=~(ia*d)); always -> INIT_Q.
REQ-014 INIT_Q: sel_muxa=2, sel_muxb=1, enC=1, enA=enB=0 (regC<=ia*x); always -> ITER_Q.
REQ-015 ITER_Q: sel_muxa=0, sel_muxb=3, enC=1, enA=enB=0 (regC<=K*Q); if iter_cnt==ITERS-1 -> DONE, else -> ITER_D.
REQ-016 ITER_D: sel_muxa=0, sel_muxb=2, enA=1, enB=1, enC=0 (regB<=K*D, regA<=~(K*D)); iter_cnt increments by 1; -> ITER_Q.
REQ-017 ITER_Q precedes ITER_D in every iteration, so the quotient update uses regA before it is overwritten.
REQ-018 The final iteration has no ITER_D; exactly ITERS ITER_Q cycles and ITERS-1 ITER_D cycles per division.
REQ-019 busy=1 in INIT_D, INIT_Q, ITER_Q and ITER_D; 0 in IDLE and DONE.
REQ-020 DONE: done=1, all enables 0, selects 0; lasts exactly one cycle; start=1 -> INIT_D (back-to-back, iter_cnt cleared), else -> IDLE.
REQ-021 Latency: start sampled at edge T; INIT_D occupies cycle T+1; done is high in cycle T+2*ITERS+2; busy is high for 2*ITERS+1 cycles.
REQ-022 start while busy=1 is ignored: no restart, no queuing, no effect on the sequence.
REQ-023 At most one of enC and enB is high in any cycle; enA is high only together with enB.
REQ-024 iter_cnt holds its value in all states except ITER_D (increment) and start acceptance (clear); it never exceeds ITERS-1.
REQ-025 d and x are held stable by the source from start acceptance until done; the block does not check this.

Reset
REQ-026 reset=1 at a rising edge forces IDLE, iter_cnt=0, and all outputs to their IDLE values in the following cycle, regardless of state.
REQ-027 reset has priority over start; start sampled in the same edge as reset is dropped.
REQ-028 Reset mid-sequence aborts the division without a done pulse; a start on the first edge after reset deasserts is accepted normally.

Verification
REQ-029 ITERS=3, single start pulse from IDLE -> state sequence INIT_D, INIT_Q, ITER_Q, ITER_D, ITER_Q, ITER_D, ITER_Q, DONE; busy high for 7 cycles; done high for 1 cycle; per-cycle sel/en values exactly as REQ-013..REQ-016.
REQ-030 Datapath co-simulation with d=0x4000000 (1.0), x=0x6000000 (1.5), ITERS=3 -> regC approximately 0x6000000 at done, within 2 LSB.
REQ-031 start held high continuously for 20 cycles, ITERS=2 -> done every 6 cycles (5 busy cycles + DONE); no extra IDLE cycle between divisions.
REQ-032 start pulsed in INIT_Q and again in ITER_D -> sequence unchanged; exactly one done.
REQ-033 reset asserted during the second ITER_Q -> IDLE next cycle, enables 0, no done; restart completes normally.
REQ-034 ITERS=1 -> INIT_D, INIT_Q, ITER_Q, DONE; enB never asserted after INIT_D; iter_cnt stays 0.
